// File: rtl/memory_tester_pkg.sv
// Shared encodings for the RAM self-test engine: pattern modes, FSM states
// and small helpers used by the top and the pattern generator.
package memory_tester_pkg;

    localparam int unsigned MODE_WIDTH  = 2;
    localparam int unsigned STATE_WIDTH = 3;
    localparam int unsigned DRAIN_WIDTH = 3;

    typedef enum logic [MODE_WIDTH-1:0] {
        MODE_ADDR   = 2'd0,
        MODE_NADDR  = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_NCHECK = 2'd3
    } mode_e;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == ST_WRITE) || (s == ST_READ) || (s == ST_DRAIN);
    endfunction

    function automatic logic can_start(input state_e s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/memory_pattern.sv
// Combinational test-pattern generator: maps (mode, address) to the data word
// written to and expected back from the RAM.
module memory_pattern
    import memory_tester_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic [MODE_WIDTH-1:0] mode,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int unsigned HALF_WIDTH = DATA_WIDTH / 2;

    logic [DATA_WIDTH-1:0] addr_pat;
    logic [DATA_WIDTH-1:0] check_pat;

    always_comb begin
        addr_pat  = DATA_WIDTH'(addr);
        check_pat = addr[0] ? {HALF_WIDTH{2'b10}} : {HALF_WIDTH{2'b01}};
        data      = addr_pat;
        unique case (mode_e'(mode))
            MODE_ADDR:   data = addr_pat;
            MODE_NADDR:  data = ~addr_pat;
            MODE_CHECK:  data = check_pat;
            MODE_NCHECK: data = ~check_pat;
            default:     data = addr_pat;
        endcase
    end

endmodule

// File: rtl/memory_tester.sv
// Block-RAM self-test engine: writes a pattern to every address, reads it all
// back through a latency-matched compare pipeline, and reports the results.
module memory_tester
    import memory_tester_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned ERR_WIDTH    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [MODE_WIDTH-1:0] mode,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_read,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = '1;
    localparam logic [DRAIN_WIDTH-1:0] LAST_DRAIN = DRAIN_WIDTH'(READ_LATENCY - 1);
    localparam logic [ERR_WIDTH-1:0]   ERR_MAX    = '1;

    state_e                  state;
    state_e                  state_next;
    logic                    accept;
    mode_e                   mode_q;
    mode_e                   mode_next;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]   cnt_next;
    logic [DRAIN_WIDTH-1:0]  drain_cnt;
    logic [DRAIN_WIDTH-1:0]  drain_next;
    logic [ERR_WIDTH-1:0]    err_next;
    logic [ADDR_WIDTH-1:0]   fail_next;
    logic [DATA_WIDTH-1:0]   wr_pattern;
    logic [DATA_WIDTH-1:0]   cmp_pattern;

    // Read tracking pipeline, one stage per cycle of RAM read latency
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [ADDR_WIDTH-1:0]   pipe_addr [READ_LATENCY];
    logic                    cmp_valid;
    logic [ADDR_WIDTH-1:0]   cmp_addr;

    assign cmp_valid = pipe_valid[READ_LATENCY-1];
    assign cmp_addr  = pipe_addr[READ_LATENCY-1];

    // Write data is computed for the next cycle so ram_wdata can be registered
    memory_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_pattern (
        .mode (mode_next),
        .addr (cnt_next),
        .data (wr_pattern)
    );

    memory_pattern #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_cmp_pattern (
        .mode (mode_q),
        .addr (cmp_addr),
        .data (cmp_pattern)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_WRITE;
            ST_WRITE: if (cnt == LAST_ADDR) state_next = ST_READ;
            ST_READ:  if (cnt == LAST_ADDR) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == LAST_DRAIN) state_next = ST_DONE;
            ST_DONE:  if (start) state_next = ST_WRITE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Next values of the counters, latched mode and result registers
    always_comb begin
        accept     = start && can_start(state);
        mode_next  = accept ? mode_e'(mode) : mode_q;
        cnt_next   = cnt;
        drain_next = drain_cnt;
        err_next   = error_count;
        fail_next  = fail_addr;

        if (accept) begin
            cnt_next   = '0;
            drain_next = '0;
        end else if ((state == ST_WRITE) || (state == ST_READ)) begin
            cnt_next = cnt + ADDR_WIDTH'(1);
        end else if (state == ST_DRAIN) begin
            drain_next = drain_cnt + DRAIN_WIDTH'(1);
        end

        if (accept) begin
            err_next  = '0;
            fail_next = '0;
        end else if (cmp_valid && (ram_rdata != cmp_pattern)) begin
            // A saturated counter never returns to zero, so zero marks the first miss
            if (error_count == '0) begin
                fail_next = cmp_addr;
            end
            if (error_count != ERR_MAX) begin
                err_next = error_count + ERR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q      <= MODE_ADDR;
            cnt         <= '0;
            drain_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            error_count <= '0;
            fail_addr   <= '0;
            ram_waddr   <= '0;
            ram_wdata   <= '0;
            ram_write   <= 1'b0;
            ram_raddr   <= '0;
            ram_read    <= 1'b0;
        end else begin
            mode_q      <= mode_next;
            cnt         <= cnt_next;
            drain_cnt   <= drain_next;
            busy        <= is_busy(state_next);
            done        <= (state_next == ST_DONE);
            pass        <= (state_next == ST_DONE) && (err_next == '0);
            error_count <= err_next;
            fail_addr   <= fail_next;
            ram_waddr   <= cnt_next;
            ram_wdata   <= wr_pattern;
            ram_write   <= (state_next == ST_WRITE);
            ram_raddr   <= cnt_next;
            ram_read    <= (state_next == ST_READ);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_addr[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= ram_read;
            pipe_addr[0]  <= ram_raddr;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_addr[i]  <= pipe_addr[i-1];
            end
        end
    end

endmodule

// File: tb/tb_memory_tester.sv
// Directed bench for memory_tester: three instances (latency 2/1/4) each
// attached to a small behavioural RAM with optional fault injection.
module tb_memory_tester;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode  = 2'd0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       start_c = 1'b0;
    logic       stuck   = 1'b0;
    logic       force_zero = 1'b0;

    int total = 0;
    int bad   = 0;
    int cycles;

    always #5 clock = ~clock;

    // Instance A: ADDR_WIDTH=4, READ_LATENCY=2, ERR_WIDTH=16
    logic        busy_a, done_a, pass_a, wr_a, rd_a;
    logic [15:0] err_a;
    logic [3:0]  fail_a, waddr_a, raddr_a;
    logic [7:0]  wdata_a, rdata_a;
    logic [7:0]  mem_a [16];
    logic [7:0]  rp_a  [2];
    logic [7:0]  w4, w5, w7;

    memory_tester #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(2), .ERR_WIDTH(16)) u_a (
        .clock(clock), .reset(reset), .start(start_a), .mode(mode),
        .busy(busy_a), .done(done_a), .pass(pass_a), .error_count(err_a), .fail_addr(fail_a),
        .ram_waddr(waddr_a), .ram_wdata(wdata_a), .ram_write(wr_a),
        .ram_raddr(raddr_a), .ram_read(rd_a), .ram_rdata(rdata_a)
    );

    always @(posedge clock) begin
        if (wr_a) mem_a[waddr_a] <= (stuck && waddr_a == 4'd6) ? (wdata_a | 8'h08) : wdata_a;
        if (rd_a) rp_a[0] <= mem_a[raddr_a];
        rp_a[1] <= rp_a[0];
        if (wr_a && waddr_a == 4'd4) w4 <= wdata_a;
        if (wr_a && waddr_a == 4'd5) w5 <= wdata_a;
        if (wr_a && waddr_a == 4'd7) w7 <= wdata_a;
    end
    assign rdata_a = rp_a[1];

    // Instance B: READ_LATENCY=1, ERR_WIDTH=2
    logic        busy_b, done_b, pass_b, wr_b, rd_b;
    logic [1:0]  err_b;
    logic [3:0]  fail_b, waddr_b, raddr_b;
    logic [7:0]  wdata_b, rdata_b;
    logic [7:0]  mem_b [16];
    logic [7:0]  rp_b;

    memory_tester #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1), .ERR_WIDTH(2)) u_b (
        .clock(clock), .reset(reset), .start(start_b), .mode(mode),
        .busy(busy_b), .done(done_b), .pass(pass_b), .error_count(err_b), .fail_addr(fail_b),
        .ram_waddr(waddr_b), .ram_wdata(wdata_b), .ram_write(wr_b),
        .ram_raddr(raddr_b), .ram_read(rd_b), .ram_rdata(rdata_b)
    );

    always @(posedge clock) begin
        if (wr_b) mem_b[waddr_b] <= wdata_b;
        if (rd_b) rp_b <= mem_b[raddr_b];
    end
    assign rdata_b = force_zero ? 8'h00 : rp_b;

    // Instance C: READ_LATENCY=4
    logic        busy_c, done_c, pass_c, wr_c, rd_c;
    logic [15:0] err_c;
    logic [3:0]  fail_c, waddr_c, raddr_c;
    logic [7:0]  wdata_c, rdata_c;
    logic [7:0]  mem_c [16];
    logic [7:0]  rp_c  [4];

    memory_tester #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(4), .ERR_WIDTH(16)) u_c (
        .clock(clock), .reset(reset), .start(start_c), .mode(mode),
        .busy(busy_c), .done(done_c), .pass(pass_c), .error_count(err_c), .fail_addr(fail_c),
        .ram_waddr(waddr_c), .ram_wdata(wdata_c), .ram_write(wr_c),
        .ram_raddr(raddr_c), .ram_read(rd_c), .ram_rdata(rdata_c)
    );

    always @(posedge clock) begin
        if (wr_c) mem_c[waddr_c] <= wdata_c;
        if (rd_c) rp_c[0] <= mem_c[raddr_c];
        rp_c[1] <= rp_c[0];
        rp_c[2] <= rp_c[1];
        rp_c[3] <= rp_c[2];
    end
    assign rdata_c = rp_c[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic busy_of(input int which);
        case (which)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    task automatic set_start(input int which, input logic v);
        case (which)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    // Pulse start, then count busy cycles at falling edges; optionally poke
    // start again at a given cycle or stop early at a given cycle.
    task automatic run(input int which, input logic [1:0] m, input int poke_at,
                       input int stop_at, output int n);
        @(negedge clock);
        mode = m;
        set_start(which, 1'b1);
        @(negedge clock);
        set_start(which, 1'b0);
        n = 0;
        while (busy_of(which) && n < 200 && n != stop_at) begin
            n++;
            set_start(which, n == poke_at);
            @(negedge clock);
        end
        set_start(which, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy",  32'(busy_a), 32'd0);
        check("rst_done",  32'(done_a), 32'd0);
        check("rst_pass",  32'(pass_a), 32'd0);
        check("rst_err",   32'(err_a),  32'd0);
        check("rst_fail",  32'(fail_a), 32'd0);
        check("rst_write", 32'(wr_a),   32'd0);
        check("rst_read",  32'(rd_a),   32'd0);

        // Mode 0 on an ideal RAM
        run(0, 2'd0, -1, -1, cycles);
        check("m0_len",  32'(cycles), 32'd34);
        check("m0_done", 32'(done_a), 32'd1);
        check("m0_pass", 32'(pass_a), 32'd1);
        check("m0_err",  32'(err_a),  32'd0);
        check("m0_w5",   32'(w5),     32'h05);
        repeat (3) @(negedge clock);
        check("m0_done_hold", 32'(done_a), 32'd1);
        check("m0_busy_idle", 32'(busy_a), 32'd0);

        // Checkerboard
        run(0, 2'd2, -1, -1, cycles);
        check("m2_len",  32'(cycles), 32'd34);
        check("m2_pass", 32'(pass_a), 32'd1);
        check("m2_w4",   32'(w4),     32'h55);
        check("m2_w7",   32'(w7),     32'hAA);

        // Bit 3 stuck-at-1 at address 6
        stuck = 1'b1;
        run(0, 2'd0, -1, -1, cycles);
        stuck = 1'b0;
        check("stk_done", 32'(done_a), 32'd1);
        check("stk_err",  32'(err_a),  32'd1);
        check("stk_fail", 32'(fail_a), 32'd6);
        check("stk_pass", 32'(pass_a), 32'd0);

        // Start mid-WRITE is ignored; new run also clears the previous failure
        run(0, 2'd1, 5, -1, cycles);
        check("poke_len",  32'(cycles), 32'd34);
        check("poke_pass", 32'(pass_a), 32'd1);
        check("poke_err",  32'(err_a),  32'd0);

        // Start in the cycle done rises is not accepted
        run(0, 2'd3, 34, -1, cycles);
        check("late_len", 32'(cycles), 32'd34);
        @(negedge clock);
        check("late_busy", 32'(busy_a), 32'd0);
        check("late_done", 32'(done_a), 32'd1);

        // Reset mid-READ after an error has been recorded
        stuck = 1'b1;
        run(0, 2'd0, -1, 28, cycles);
        check("mid_busy", 32'(busy_a), 32'd1);
        check("mid_err",  32'(err_a),  32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mr_busy",  32'(busy_a), 32'd0);
        check("mr_done",  32'(done_a), 32'd0);
        check("mr_pass",  32'(pass_a), 32'd0);
        check("mr_err",   32'(err_a),  32'd0);
        check("mr_fail",  32'(fail_a), 32'd0);
        check("mr_read",  32'(rd_a),   32'd0);
        check("mr_write", 32'(wr_a),   32'd0);
        reset = 1'b0;
        stuck = 1'b0;
        run(0, 2'd0, -1, -1, cycles);
        check("after_len",  32'(cycles), 32'd34);
        check("after_pass", 32'(pass_a), 32'd1);

        // READ_LATENCY=1
        run(1, 2'd0, -1, -1, cycles);
        check("l1_len",  32'(cycles), 32'd33);
        check("l1_pass", 32'(pass_b), 32'd1);

        // ERR_WIDTH=2 saturation with read data stuck at zero
        force_zero = 1'b1;
        run(1, 2'd1, -1, -1, cycles);
        force_zero = 1'b0;
        check("sat_err",  32'(err_b),  32'd3);
        check("sat_fail", 32'(fail_b), 32'd0);
        check("sat_pass", 32'(pass_b), 32'd0);
        check("sat_done", 32'(done_b), 32'd1);

        // READ_LATENCY=4
        run(2, 2'd3, -1, -1, cycles);
        check("l4_len",  32'(cycles), 32'd36);
        check("l4_pass", 32'(pass_c), 32'd1);
        check("l4_err",  32'(err_c),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
